// File: rtl/poly_carry_norm.sv
// Word-serial carry propagation from redundant coefficients to canonical words.
// One coefficient is normalized per cycle; the final carry lands in o_carry.
module poly_carry_norm #(
    parameter int WORD_BITS       = 16,
    parameter int NUM_WORDS       = 64,
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD          = NUM_WORDS + 1,
    parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_val,
    output logic                                o_rdy,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]    i_dat,
    output logic                                o_val,
    input  logic                                i_rdy,
    output logic [I_WORD-1:0][WORD_BITS-1:0]    o_dat,
    output logic [REDUN_WORD_BITS:0]            o_carry
);

    localparam int CNT_W = $clog2(I_WORD + 1);
    localparam int SUM_W = COEF_BITS + 1;
    localparam int CAR_W = REDUN_WORD_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                           state;
    state_t                           state_nx;
    logic [CNT_W-1:0]                 cnt;
    logic [CAR_W-1:0]                 carry;
    logic [CAR_W-1:0]                 carry_nx;
    logic [SUM_W-1:0]                 sum;
    logic [I_WORD-1:0][COEF_BITS-1:0] coef;
    logic                             last;

    assign last  = (cnt == CNT_W'(I_WORD - 1));
    assign o_rdy = (state == IDLE);
    assign o_val = (state == DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (i_val) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    if (i_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The upper sum bits are the carry; they never exceed CAR_W bits.
    always_comb begin
        sum      = SUM_W'(coef[cnt]) + SUM_W'(carry);
        carry_nx = sum[SUM_W-1:WORD_BITS];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            carry   <= '0;
            coef    <= '0;
            o_dat   <= '0;
            o_carry <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_val) begin
                        coef  <= i_dat;
                        carry <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    o_dat[cnt] <= sum[WORD_BITS-1:0];
                    carry      <= carry_nx;
                    cnt        <= cnt + 1'b1;
                    if (last) begin
                        o_carry <= carry_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_carry_norm.sv
// Bench for poly_carry_norm: big-integer value model plus directed pins.
// Every o_val cycle is checked against the summed value of the accepted input.
module tb_poly_carry_norm;

    localparam int WB  = 16;
    localparam int NW  = 64;
    localparam int RB  = 1;
    localparam int IW  = NW + 1;
    localparam int CB  = WB + RB;
    localparam int TOT = WB * IW + RB + 1;

    typedef logic [IW-1:0][CB-1:0] coefs_t;
    typedef logic [IW-1:0][WB-1:0] words_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_val;
    logic          o_rdy;
    coefs_t        i_dat;
    logic          o_val;
    logic          i_rdy;
    words_t        o_dat;
    logic [RB:0]   o_carry;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int nacc  = 0;
    int nres  = 0;
    bit seen  = 1'b0;
    bit soak_on = 1'b0;

    coefs_t q[$];
    int     qc[$];

    poly_carry_norm dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_val   (i_val),
        .o_rdy   (o_rdy),
        .i_dat   (i_dat),
        .o_val   (o_val),
        .i_rdy   (i_rdy),
        .o_dat   (o_dat),
        .o_carry (o_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_words(string name, words_t got, words_t exp);
        int idx = 0;
        for (int i = IW - 1; i >= 0; i--) begin
            if (got[i] !== exp[i]) idx = i;
        end
        chk($sformatf("%s[%0d]", name, idx), 64'(got[idx]), 64'(exp[idx]));
    endtask

    // Integer value the coefficients represent.
    function automatic logic [TOT-1:0] value_of(coefs_t c);
        logic [TOT-1:0] t;
        t = '0;
        for (int i = 0; i < IW; i++) begin
            t = t + (TOT'(c[i]) << (WB * i));
        end
        return t;
    endfunction

    function automatic coefs_t rand_coefs();
        coefs_t c;
        for (int i = 0; i < IW; i++) begin
            c[i] = CB'($urandom_range(0, 32'h1FFFF));
        end
        return c;
    endfunction

    always @(negedge clk) begin
        logic [TOT-1:0] v;
        if (!rst) begin
            if (o_val) begin
                chk("o_rdy_in_done", 64'(o_rdy), 64'(0));
                chk("pending_results", 64'(q.size()), 64'(1));
                if (q.size() != 0) begin
                    v = value_of(q[0]);
                    chk_words("o_dat", o_dat, v[WB*IW-1:0]);
                    chk("o_carry", 64'(o_carry), 64'(v[TOT-1 -: RB+1]));
                    if (!seen) chk("latency", 64'(cyc - qc[0]), 64'(IW));
                    seen = 1'b1;
                    if (i_rdy) begin
                        void'(q.pop_front());
                        void'(qc.pop_front());
                        seen = 1'b0;
                        nres++;
                    end
                end
            end
            if (i_val && o_rdy) begin
                q.push_back(i_dat);
                qc.push_back(cyc + 1);
                nacc++;
            end
        end
    end

    task automatic send(coefs_t c);
        int k;
        i_dat = c;
        i_val = 1'b1;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (o_rdy) break;
        end
        if (k == 500) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout got no o_rdy expected o_rdy within 500 cycles");
        end
        @(posedge clk);
        #1;
        i_val = 1'b0;
        i_dat = rand_coefs();
    endtask

    task automatic wait_val();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_val) break;
        end
        if (k == 200) begin
            tests++;
            fails++;
            $display("FAIL val_timeout got no o_val expected o_val within 200 cycles");
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (q.size() == 0 && o_rdy) break;
        end
        if (k == 500) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        coefs_t c;
        rst   = 1'b1;
        i_val = 1'b0;
        i_rdy = 1'b0;
        i_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_val", 64'(o_val), 64'(0));
        chk("rst_o_rdy", 64'(o_rdy), 64'(1));
        chk("rst_o_dat", 64'(|o_dat), 64'(0));
        chk("rst_o_carry", 64'(o_carry), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < IW; i++) c[i] = CB'(i);
        i_rdy = 1'b1;
        send(c);
        wait_val();
        chk("pass_w7", 64'(o_dat[7]), 64'h7);
        chk("pass_w64", 64'(o_dat[64]), 64'h40);
        chk("pass_carry", 64'(o_carry), 64'h0);
        drain();

        for (int i = 0; i < IW; i++) c[i] = 17'h0FFFF;
        c[0] = 17'h10000;
        send(c);
        wait_val();
        chk("ripple_w0", 64'(o_dat[0]), 64'h0);
        chk("ripple_w64", 64'(o_dat[64]), 64'h0);
        chk("ripple_any", 64'(|o_dat), 64'h0);
        chk("ripple_carry", 64'(o_carry), 64'h1);
        drain();

        for (int i = 0; i < IW; i++) c[i] = 17'h1FFFF;
        send(c);
        wait_val();
        chk("max_w0", 64'(o_dat[0]), 64'hFFFF);
        chk("max_w1", 64'(o_dat[1]), 64'h0);
        chk("max_w2", 64'(o_dat[2]), 64'h1);
        chk("max_w64", 64'(o_dat[64]), 64'h1);
        chk("max_carry", 64'(o_carry), 64'h2);
        drain();

        for (int i = 0; i < IW; i++) c[i] = 17'h1FFFF;
        send(c);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        nacc -= q.size();
        q.delete();
        qc.delete();
        seen = 1'b0;
        #1;
        chk("mid_rst_o_val", 64'(o_val), 64'(0));
        chk("mid_rst_o_rdy", 64'(o_rdy), 64'(1));
        chk("mid_rst_o_dat", 64'(|o_dat), 64'(0));
        chk("mid_rst_o_carry", 64'(o_carry), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < IW; i++) c[i] = 17'h01234;
        send(c);
        wait_val();
        chk("post_rst_w0", 64'(o_dat[0]), 64'h1234);
        chk("post_rst_w64", 64'(o_dat[64]), 64'h1234);
        chk("post_rst_carry", 64'(o_carry), 64'h0);
        drain();

        i_rdy = 1'b0;
        send(rand_coefs());
        wait_val();
        @(posedge clk);
        #1;
        i_dat = rand_coefs();
        i_val = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_o_rdy", 64'(o_rdy), 64'(0));
            chk("bp_o_val", 64'(o_val), 64'(1));
        end
        @(posedge clk);
        #1;
        i_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_after_xfer_val", 64'(o_val), 64'(0));
        chk("bp_after_xfer_rdy", 64'(o_rdy), 64'(1));
        @(posedge clk);
        #1;
        i_val = 1'b0;
        chk("bp_accepted", 64'(o_rdy), 64'(0));
        wait_val();
        drain();

        soak_on = 1'b1;
        fork
            begin
                while (soak_on) begin
                    @(posedge clk);
                    #1;
                    if (soak_on) i_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join_none
        for (int n = 0; n < 500; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            c = rand_coefs();
            if (n % 9 == 0) begin
                for (int i = 0; i < IW; i++) c[i] = 17'h1FFFF;
            end
            send(c);
        end
        soak_on = 1'b0;
        @(posedge clk);
        #2;
        i_rdy = 1'b1;
        drain();

        chk("results_vs_accepts", 64'(nres), 64'(nacc));
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
